track_ctrl: RTL and testbench



---
 rtl/track_pkg.sv | 17 +
 rtl/track_ctrl_frame_judge.sv | 59 +++++
 rtl/track_ctrl.sv | 111 +++++++++++
 tb/tb_track_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/track_pkg.sv
// Shared types and defaults for the tracking controller.
package track_pkg;

    localparam int SCORE_W = 16;
    localparam logic [SCORE_W-1:0] SCORE_THRESH_DEF = 16'd4096;
    localparam int LOST_FRAMES_DEF = 4;
    localparam int BAD_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_TRACK   = 3'd3,
        ST_LOST    = 3'd4
    } track_state_t;

endpackage

// File: rtl/track_ctrl_frame_judge.sv
// Per-frame match judgement: good latch, bad-frame run length and good-frame count.
module frame_judge
    import track_pkg::*;
#(
    parameter int SCORE_W = track_pkg::SCORE_W,
    parameter logic [SCORE_W-1:0] SCORE_THRESH = track_pkg::SCORE_THRESH_DEF,
    parameter int LOST_FRAMES = track_pkg::LOST_FRAMES_DEF,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               eval,
    input  logic               max_ready,
    input  logic [SCORE_W-1:0] max_score,
    output logic               frame_good,
    output logic               frame_bad,
    output logic               lost_hit,
    output logic [CNT_W-1:0]   frames_tracked
);

    logic             good_q;
    logic [BAD_W-1:0] bad_cnt;
    logic             score_ok;
    logic             frame_ok;

    assign score_ok = (max_score >= SCORE_THRESH);
    // A result arriving with frame_start still belongs to the frame that is ending.
    assign frame_ok   = max_ready ? score_ok : good_q;
    assign frame_good = eval & frame_ok;
    assign frame_bad  = eval & ~frame_ok;
    assign lost_hit   = frame_bad && (bad_cnt == BAD_W'(LOST_FRAMES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_q         <= 1'b0;
            bad_cnt        <= '0;
            frames_tracked <= '0;
        end else if (clear) begin
            good_q         <= 1'b0;
            bad_cnt        <= '0;
            frames_tracked <= '0;
        end else begin
            if (eval)
                good_q <= 1'b0;
            else if (max_ready)
                good_q <= score_ok;

            if (frame_good) begin
                bad_cnt <= '0;
                if (frames_tracked != '1)
                    frames_tracked <= frames_tracked + 1'b1;
            end else if (frame_bad && (bad_cnt < BAD_W'(LOST_FRAMES))) begin
                bad_cnt <= bad_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/track_ctrl.sv
// Box/tracking sequencer: manual positioning, template capture, per-frame search.
// TRACK_REACQUIRE_EN: LOST keeps searching and a good frame returns to TRACK.
//
// state   | meaning
// IDLE    | manual box positioning
// ARM     | capture requested, waiting for top of frame
// CAPTURE | writing template store for one frame
// TRACK   | box follows match result, one search per frame
// LOST    | too many consecutive bad frames
module track_ctrl
    import track_pkg::*;
#(
    parameter int SCORE_W = track_pkg::SCORE_W,
    parameter logic [SCORE_W-1:0] SCORE_THRESH = track_pkg::SCORE_THRESH_DEF,
    parameter int LOST_FRAMES = track_pkg::LOST_FRAMES_DEF,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               capture_req,
    input  logic               cancel,
    input  logic               frame_start,
    input  logic               template_in_box,
    input  logic               max_ready,
    input  logic [SCORE_W-1:0] max_score,
    output logic               tracking_mode,
    output logic               template_we,
    output logic               search_start,
    output logic               template_done,
    output logic               lost,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   frames_tracked
);

`ifdef TRACK_REACQUIRE_EN
    localparam bit REACQ = 1'b1;
`else
    localparam bit REACQ = 1'b0;
`endif

    track_state_t state, state_nxt;
    logic override, active, eval, clear, follow_nxt;
    logic frame_good, frame_bad, lost_hit;

    assign active   = (state == ST_TRACK) || (REACQ && (state == ST_LOST));
    assign override = (cancel && (state != ST_IDLE)) ||
                      (capture_req && ((state == ST_IDLE) || (state == ST_TRACK) ||
                                       (state == ST_LOST)));
    assign eval  = frame_start && active && !override;
    assign clear = frame_start && (state == ST_CAPTURE) && !override;

    frame_judge #(
        .SCORE_W      (SCORE_W),
        .SCORE_THRESH (SCORE_THRESH),
        .LOST_FRAMES  (LOST_FRAMES),
        .CNT_W        (CNT_W)
    ) u_judge (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .eval           (eval),
        .max_ready      (max_ready),
        .max_score      (max_score),
        .frame_good     (frame_good),
        .frame_bad      (frame_bad),
        .lost_hit       (lost_hit),
        .frames_tracked (frames_tracked)
    );

    always_comb begin
        state_nxt = state;
        if (cancel && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end else if (capture_req && ((state == ST_IDLE) || (state == ST_TRACK) ||
                                     (state == ST_LOST))) begin
            state_nxt = ST_ARM;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_IDLE;
                ST_ARM:     if (frame_start) state_nxt = ST_CAPTURE;
                ST_CAPTURE: if (frame_start) state_nxt = ST_TRACK;
                ST_TRACK:   if (lost_hit)    state_nxt = ST_LOST;
                ST_LOST:    if (frame_good)  state_nxt = ST_TRACK;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // A search is only launched for frames in which the box will follow the matcher.
    assign follow_nxt = (state_nxt == ST_TRACK) || (REACQ && (state_nxt == ST_LOST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            tracking_mode <= 1'b0;
            search_start  <= 1'b0;
            template_done <= 1'b0;
            lost          <= 1'b0;
        end else begin
            state         <= state_nxt;
            tracking_mode <= follow_nxt;
            search_start  <= frame_start && follow_nxt;
            template_done <= clear;
            lost          <= (state_nxt == ST_LOST);
        end
    end

    assign template_we = (state == ST_CAPTURE) && template_in_box;
    assign state_o     = state;

endmodule

// File: tb/tb_track_ctrl.sv
// Randomized self-checking bench for track_ctrl against a frame-level behavioural model.
module tb_track_ctrl;

    localparam int T  = 4096;
    localparam int LF = 4;
`ifdef TRACK_REACQUIRE_EN
    localparam bit REACQ = 1'b1;
`else
    localparam bit REACQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        capture_req = 1'b0, cancel = 1'b0, frame_start = 1'b0;
    logic        template_in_box = 1'b0, max_ready = 1'b0;
    logic [15:0] max_score = '0;
    logic        tracking_mode, template_we, search_start, template_done, lost;
    logic [2:0]  state_o;
    logic [15:0] frames_tracked;

    always #5 clk = ~clk;

    track_ctrl #(
        .SCORE_W(16), .SCORE_THRESH(16'd4096), .LOST_FRAMES(LF), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .capture_req(capture_req), .cancel(cancel),
        .frame_start(frame_start), .template_in_box(template_in_box),
        .max_ready(max_ready), .max_score(max_score),
        .tracking_mode(tracking_mode), .template_we(template_we),
        .search_start(search_start), .template_done(template_done), .lost(lost),
        .state_o(state_o), .frames_tracked(frames_tracked)
    );

    int n_tests = 0, n_fail = 0, we_cnt = 0, ss_cnt = 0;

    // Model: mode 0 idle,1 arm,2 capture,3 track,4 lost
    int m_state, m_bad, m_ft;
    bit m_good, m_tm, m_lost, m_ss, m_td;

    function automatic void model_reset();
        m_state = 0; m_bad = 0; m_ft = 0; m_good = 0;
        m_tm = 0; m_lost = 0; m_ss = 0; m_td = 0;
    endfunction

    function automatic void model_step(bit cr, bit cn, bit fs, bit mr, int ms);
        int nst;
        bit g;
        nst = m_state;
        m_td = 0;
        if (cn && m_state != 0) nst = 0;
        else if (cr && (m_state == 0 || m_state == 3 || m_state == 4)) nst = 1;
        else begin
            if (m_state == 1 && fs) nst = 2;
            else if (m_state == 2 && fs) begin
                nst = 3; m_td = 1; m_ft = 0; m_bad = 0; m_good = 0;
            end else if ((m_state == 3 || (REACQ && m_state == 4)) && fs) begin
                g = mr ? (ms >= T) : m_good;
                m_good = 0;
                if (g) begin
                    m_bad = 0;
                    if (m_ft < 65535) m_ft++;
                    nst = 3;
                end else begin
                    if (m_bad < LF) m_bad++;
                    if (m_bad == LF) nst = 4;
                end
            end else if (mr) m_good = (ms >= T);
        end
        m_tm    = (nst == 3) || (REACQ && nst == 4);
        m_ss    = fs && m_tm;
        m_lost  = (nst == 4);
        m_state = nst;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("state_o", int'(state_o), m_state);
            check("tracking_mode", int'(tracking_mode), int'(m_tm));
            check("search_start", int'(search_start), int'(m_ss));
            check("template_done", int'(template_done), int'(m_td));
            check("lost", int'(lost), int'(m_lost));
            check("frames_tracked", int'(frames_tracked), m_ft);
            check("template_we", int'(template_we), int'(m_state == 2 && template_in_box));
            we_cnt += int'(template_we);
            ss_cnt += int'(search_start);
        end
    end

    task automatic tick(input bit cr, input bit cn, input bit fs, input bit tib,
                        input bit mr, input int ms);
        capture_req = cr; cancel = cn; frame_start = fs;
        template_in_box = tib; max_ready = mr; max_score = 16'(ms);
        @(posedge clk);
        model_step(cr, cn, fs, mr, ms);
        #1;
    endtask

    task automatic frame(input bit has_mr, input int ms);
        repeat (3) tick(0, 0, 0, 0, 0, 0);
        if (has_mr) tick(0, 0, 0, 0, 1, ms);
        repeat (2) tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        int ms;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(state_o), 0);
        check("rst_tm", int'(tracking_mode), 0);
        check("rst_ft", int'(frames_tracked), 0);
        rst_n = 1'b1;
        tick(0, 0, 0, 0, 0, 0);

        // capture flow
        tick(1, 0, 0, 0, 0, 0);
        check("arm_state", int'(state_o), 1);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        we_cnt = 0;
        repeat (100) tick(0, 0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        check("we_count", we_cnt, 100);
        check("cap_done", int'(template_done), 1);
        check("cap_tm", int'(tracking_mode), 1);
        check("cap_state", int'(state_o), 3);

        // five good frames
        ss_cnt = 0;
        repeat (5) frame(1, 5000);
        tick(0, 0, 0, 0, 0, 0);
        check("good_ft", int'(frames_tracked), 5);
        check("good_lost", int'(lost), 0);
        check("good_ss", ss_cnt, 6);

        // lost detection
        repeat (3) frame(1, 100);
        check("bad3_state", int'(state_o), 3);
        frame(1, 5000);
        check("recover_ft", int'(frames_tracked), 6);
        repeat (3) frame(0, 0);
        check("miss3_state", int'(state_o), 3);
        frame(0, 0);
        check("lost_state", int'(state_o), 4);
        check("lost_flag", int'(lost), 1);
        check("lost_tm", int'(tracking_mode), REACQ ? 1 : 0);

        // reacquire attempt
        frame(1, 5000);
        check("reacq_state", int'(state_o), REACQ ? 3 : 4);
        check("reacq_lost", int'(lost), REACQ ? 0 : 1);
        check("reacq_tm", int'(tracking_mode), REACQ ? 1 : 0);
        check("reacq_ft", int'(frames_tracked), REACQ ? 7 : 6);

        // priority: cancel beats capture_req in TRACK
        tick(1, 0, 0, 0, 0, 0);
        check("recap_state", int'(state_o), 1);
        tick(0, 0, 1, 0, 0, 0);
        repeat (5) tick(0, 0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        check("pre_prio_state", int'(state_o), 3);
        tick(1, 1, 0, 0, 0, 0);
        check("prio_state", int'(state_o), 0);
        check("prio_tm", int'(tracking_mode), 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0:       ms = 4095;
                1:       ms = 4096;
                2:       ms = int'($urandom_range(0, 4095));
                default: ms = int'($urandom_range(4096, 65535));
            endcase
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 5) == 0, ms);
        end

        // asynchronous reset in the middle of a capture
        tick(0, 1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 0);
        check("pre_rst_we", int'(template_we), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_we", int'(template_we), 0);
        check("rst_state2", int'(state_o), 0);
        check("rst_ft2", int'(frames_tracked), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick(0, 0, 0, 1, 0, 0);
        check("post_rst_state", int'(state_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
